// File: rtl/iob_cpu_bus_arbiter_pkg.sv
// Shared encodings for the CPU bus arbiter: FSM states and requester IDs.
package iob_cpu_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RD   = 2'd2
    } state_t;

    localparam logic IBUS = 1'b0;
    localparam logic DBUS = 1'b1;

endpackage

// File: rtl/iob_rr_arb2.sv
// Two-input round-robin / fixed-priority select with a last-served pointer.
module iob_rr_arb2
    import iob_cpu_bus_arbiter_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       served,
    output logic       winner
);

    logic last_reg;

    // Reset points at ibus so that dbus takes the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= IBUS;
        end else if (upd) begin
            last_reg <= served;
        end
    end

    always_comb begin
        winner = IBUS;
        if (req[1] && !req[0]) begin
            winner = DBUS;
        end else if (req == 2'b11) begin
            winner = (RR != 0) ? ~last_reg : DBUS;
        end
    end

endmodule

// File: rtl/iob_cpu_bus_arbiter.sv
// Shares one IOb native port between the CPU ibus and dbus, one transaction
// outstanding, grant locked until acceptance, responses routed to the owner.
module iob_cpu_bus_arbiter
    import iob_cpu_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR     = 1,
    localparam int WSTRB_W = DATA_W / 8,
    localparam int REQ_W   = 1 + ADDR_W + DATA_W + WSTRB_W,
    localparam int RESP_W  = DATA_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REQ_W-1:0]  ibus_req,
    output logic [RESP_W-1:0] ibus_resp,
    input  logic [REQ_W-1:0]  dbus_req,
    output logic [RESP_W-1:0] dbus_resp,
    output logic [REQ_W-1:0]  mem_req,
    input  logic [RESP_W-1:0] mem_resp,
    output logic              grant_o,
    output logic              busy_o
);

    state_t state_reg;
    logic   owner_reg;

    logic              i_avalid;
    logic              d_avalid;
    logic              win;
    logic              upd;
    logic              owner;
    logic              idle_grant;
    logic              fwd_req;
    logic              sel_write;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [REQ_W-1:0]  sel_req;
    logic [RESP_W-1:0] owner_resp;

    assign i_avalid   = ibus_req[REQ_W-1];
    assign d_avalid   = dbus_req[REQ_W-1];
    assign mem_ready  = mem_resp[0];
    assign mem_rvalid = mem_resp[1];

    iob_rr_arb2 #(
        .RR(RR)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({d_avalid, i_avalid}),
        .upd    (upd),
        .served (owner),
        .winner (win)
    );

    // Gating on rst keeps every output at zero for the whole reset pulse.
    assign idle_grant = (state_reg == IDLE) && (i_avalid || d_avalid) && !rst;
    assign owner      = (state_reg == IDLE) ? win : owner_reg;
    assign sel_req    = (owner == DBUS) ? dbus_req : ibus_req;
    assign sel_write  = |sel_req[WSTRB_W-1:0];
    assign fwd_req    = idle_grant || (state_reg == REQ);

    assign upd = (fwd_req && mem_ready && sel_write) ||
                 ((state_reg == RD) && mem_rvalid);

    always_comb begin
        mem_req    = '0;
        owner_resp = '0;
        if (fwd_req) begin
            mem_req       = sel_req;
            owner_resp[0] = mem_ready;
        end else if (state_reg == RD) begin
            // A read requester may still hold avalid; never reissue it.
            mem_req                  = {1'b0, sel_req[REQ_W-2:0]};
            owner_resp[RESP_W-1:1]   = mem_resp[RESP_W-1:1];
        end
    end

    assign ibus_resp = (owner == IBUS) ? owner_resp : '0;
    assign dbus_resp = (owner == DBUS) ? owner_resp : '0;
    assign grant_o   = idle_grant ? win : owner_reg;
    assign busy_o    = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            owner_reg <= IBUS;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (idle_grant) begin
                        owner_reg <= win;
                        if (!mem_ready) begin
                            state_reg <= REQ;
                        end else if (!sel_write) begin
                            state_reg <= RD;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        state_reg <= sel_write ? IDLE : RD;
                    end
                end
                RD: begin
                    if (mem_rvalid) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
